m1_upsample_csc: RTL and testbench
==================================

# m1_upsample_csc

Streaming successor to the Milestone 1 datapath. It accepts 4:2:2 YUV pixel pairs over a valid/ready handshake and horizontally upsamples U/V to 4:4:4 with a 6-tap FIR and edge replication. It converts each pixel to 8-bit RGB and emits RGB pairs over a second valid/ready handshake. Line width and frame height are parameters; line-end flush, backpressure and per-line/per-frame framing are handled internally, so the SRAM sequencer above it only moves words.

## Interface
Parameters:
- LINE_WIDTH, default 320: pixels per line; even, ≥ 6. P = LINE_WIDTH/2 pairs per line.
- NUM_LINES, default 240: lines per frame.
- SW, default 8: sample width (Y/U/V/R/G/B).

Ports:
- CLOCK_50_I  in  1  the block's single clock.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; ignored unless the state is IDLE.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when high together with in_valid.
- in_y  in  2*SW  {Y_even, Y_odd}; even pixel in the MSBs.
- in_u  in  SW  U for the even pixel of the pair.
- in_v  in  SW  V for the even pixel of the pair.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_rgb0  out  3*SW  {R,G,B} of the even pixel.
- out_rgb1  out  3*SW  {R,G,B} of the odd pixel.
- out_last  out  1  high on the last pair of each line.
- frame_done  out  1  one-cycle pulse after the final pair of the frame is accepted downstream.

## Operation
- States: IDLE → PRIME → RUN → FLUSH → (PRIME | DONE) → IDLE.
- IDLE: start moves to PRIME. Line counter and pair counters are cleared.
- PRIME:
  - First beat of a line loads all six window taps w[0..5] with u0/v0, replicating the left edge.
  - Y pair and in_u/in_v enter a 3-deep delay line.
  - Moves to RUN.
- RUN: each accepted beat j shifts u[j]/v[j] into w[5]. Beats with j ≥ 3 emit output pair k = j−3. After beat P−1 is accepted, moves to FLUSH.
- FLUSH: three shift steps with no input, re-inserting u[P−1]/v[P−1] to replicate the right edge. These steps emit pairs P−3..P−1.
- After FLUSH, the line counter increments. The block returns to PRIME, or moves to DONE when the frame's line count is reached.
- DONE: pulses frame_done, then returns to IDLE.
- Window: after a shift, w = u[k−2..k+3], clamped to [0, P−1].
- Even-pixel chroma is w[2].
- Odd-pixel chroma: U' = clip((21·(w0+w5) − 52·(w1+w4) + 159·(w2+w3) + 128) >> 8, 0, 255). The sum is signed, 18 bits minimum. V' uses the same formula.
- CSC per pixel, signed 32-bit, with y = Y−16, u = U−128, v = V−128:
  - R = clip((76284y + 104595v) >> 16)
  - G = clip((76284y − 25624u − 53281v) >> 16)
  - B = clip((76284y + 132251u) >> 16)
  - clip saturates to [0, 2^SW−1]. The shift is arithmetic.
- Reset values: in_ready 0, out_valid 0, out_rgb0/out_rgb1 0, out_last 0, frame_done 0. State is IDLE; counters, window and delay line are 0.
- Reset mid-line discards all partial data. The next start begins a fresh frame.

## Timing
- Global pipeline enable: en = !out_valid | out_ready. All stages, the window and the delay line advance only when en is high.
- in_ready = en & (state is PRIME or RUN).
- Throughput: one pair per cycle with no backpressure.
- Latency: a shift at edge t (input accept or FLUSH step) gives out_valid at edge t+3.
  - Stage 1: FIR plus delay-line tap.
  - Stage 2: CSC products.
  - Stage 3: sum, clip and output register.
- Line overhead: 3 FLUSH cycles, plus the PRIME beat, which is accepted at full rate.
- While out_valid is high and out_ready is low:
  - Outputs hold stable.
  - in_ready is 0.
  - No beat is lost or duplicated.
- out_last accompanies pair P−1 of each line.
- frame_done is asserted the cycle after the out_last handshake of line NUM_LINES−1.
- start in any state other than IDLE has no effect.

## Configuration
- M1_FIR6_EN defined: odd-pixel chroma uses the 6-tap FIR above.
- M1_FIR6_EN undefined: odd-pixel chroma is (w2 + w3 + 1) >> 1. Window, FLUSH and latency are unchanged, so the bench timing is identical in both builds.

## Structure
- Package m1_pkg holds:
  - the state enum
  - FIR coefficients (21, 52, 159) and the rounding constant
  - CSC coefficients and offsets (16, 128)
  - a clip function parameterised by SW
- Sub-module yuv2rgb_csc holds the two-stage multiply/sum-clip pipe with an en input. It is instantiated twice, once per pixel of the pair.
- The top level holds the FSM, counters, window, delay line and FIR.

## Test plan
- Flat grey: LINE_WIDTH=8, NUM_LINES=1, all Y=U=V=128 → 4 beats, every R=G=B=130, out_last on the 4th beat only.
- Black with saturation: Y=16, U=V=128 → all channels 0. Y=255, V=255 → R=255.
- Chroma impulse: Y=16, V=128, U=128 except u2=228 → pair 1 odd pixel U'=190, B=125; pair 2 even pixel B=201. Without M1_FIR6_EN, pair 1 odd pixel U'=178.
- Backpressure: out_ready held low for 5 cycles mid-line → outputs stable, in_ready low throughout, 4 unique beats per line in order.
- Framing: NUM_LINES=2, LINE_WIDTH=8 → 8 output beats, frame_done pulses once, a start issued mid-frame is ignored.
- Reset after 2 input beats, then start → the first line's output equals a clean run; no stale data appears.

Source files
------------

// File: rtl/m1_pkg.sv
// Shared types, coefficients and saturation helper for the 4:2:2 -> RGB stream.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package m1_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRIME,
      ST_RUN,
      ST_FLUSH,
      ST_DONE
   } state_t;

   // 6-tap half-pel chroma interpolator: taps (21, -52, 159, 159, -52, 21) / 256
   localparam int FIR_C0    = 21;
   localparam int FIR_C1    = 52;
   localparam int FIR_C2    = 159;
   localparam int FIR_RND   = 128;
   localparam int FIR_SHIFT = 8;

   // BT.601 studio-range YUV -> RGB, 16.16 fixed point
   localparam int CSC_Y_OFF = 16;
   localparam int CSC_C_OFF = 128;
   localparam int CSC_KY    = 76284;
   localparam int CSC_KRV   = 104595;
   localparam int CSC_KGU   = 25624;
   localparam int CSC_KGV   = 53281;
   localparam int CSC_KBU   = 132251;
   localparam int CSC_SHIFT = 16;

   // Saturate a signed value to the unsigned range of an sw-bit sample.
   function automatic int clip_sw(input int x, input int sw);
      int hi;
      hi = (1 << sw) - 1;
      if (x < 0) return 0;
      else if (x > hi) return hi;
      else return x;
   endfunction

endpackage

// File: rtl/yuv2rgb_csc.sv
// Per-pixel YUV -> RGB colour conversion: products, then sum + saturate.
// Latency: 2 cycles of i_en (product register, then output register).
// Backpressure: whole pipe freezes while i_en is low; outputs hold.
module yuv2rgb_csc
   import m1_pkg::*;
#(
   parameter int SW = 8
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_en,
   input  logic [SW-1:0]   i_y,
   input  logic [SW-1:0]   i_u,
   input  logic [SW-1:0]   i_v,
   output logic [3*SW-1:0] o_rgb
);

   int w_y, w_u, w_v;
   int w_r, w_g, w_b;
   logic signed [31:0] r_py, r_prv, r_pgu, r_pgv, r_pbu;
   logic [3*SW-1:0] r_rgb;

   // remove the studio-range offsets
   always_comb begin
      w_y = int'(i_y) - CSC_Y_OFF;
      w_u = int'(i_u) - CSC_C_OFF;
      w_v = int'(i_v) - CSC_C_OFF;
   end

   // stage 2: the five coefficient products
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_py  <= '0;
         r_prv <= '0;
         r_pgu <= '0;
         r_pgv <= '0;
         r_pbu <= '0;
      end else if (i_en) begin
         r_py  <= CSC_KY  * w_y;
         r_prv <= CSC_KRV * w_v;
         r_pgu <= CSC_KGU * w_u;
         r_pgv <= CSC_KGV * w_v;
         r_pbu <= CSC_KBU * w_u;
      end
   end

   // per-channel sum, arithmetic shift back to integer, saturate
   always_comb begin
      w_r = clip_sw((r_py + r_prv) >>> CSC_SHIFT, SW);
      w_g = clip_sw((r_py - r_pgu - r_pgv) >>> CSC_SHIFT, SW);
      w_b = clip_sw((r_py + r_pbu) >>> CSC_SHIFT, SW);
   end

   // stage 3: output register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_rgb <= '0;
      else if (i_en) r_rgb <= {SW'(w_r), SW'(w_g), SW'(w_b)};
   end

   assign o_rgb = r_rgb;

endmodule

// File: rtl/m1_upsample_csc.sv
// 4:2:2 YUV pair stream -> 4:4:4 chroma upsample (edge-replicated window) -> RGB pair stream with line/frame framing.
// Latency: 3 cycles from a window shift (input accept or flush step) to out_valid.
// Backpressure: one global enable (!out_valid | out_ready) freezes every stage; in_ready drops while stalled.
// Build option M1_FIR6_EN selects the 6-tap odd-pixel chroma FIR; otherwise a 2-tap average is used.
module m1_upsample_csc
   import m1_pkg::*;
#(
   parameter int LINE_WIDTH = 320,
   parameter int NUM_LINES  = 240,
   parameter int SW         = 8
) (
   input  logic            CLOCK_50_I,
   input  logic            Reset,
   input  logic            start,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2*SW-1:0] in_y,
   input  logic [SW-1:0]   in_u,
   input  logic [SW-1:0]   in_v,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3*SW-1:0] out_rgb0,
   output logic [3*SW-1:0] out_rgb1,
   output logic            out_last,
   output logic            frame_done
);

   localparam int P  = LINE_WIDTH / 2;
   localparam int PW = $clog2(P + 1);
   localparam int LW = $clog2(NUM_LINES + 1);

   state_t          r_state;
   logic [PW-1:0]   r_beat;
   logic [LW-1:0]   r_line;
   logic [1:0]      r_flush;
   logic [SW-1:0]   r_wu [6];
   logic [SW-1:0]   r_wv [6];
   logic [2*SW-1:0] r_dly [3];
   logic [2*SW-1:0] r_s0_y, r_s1_y;
   logic            r_s0_vld, r_s0_last, r_s1_vld, r_s1_last, r_s2_vld, r_s2_last;
   logic            r_out_vld, r_out_last, r_frame_done;
   logic [SW-1:0]   r_s1_ue, r_s1_ve, r_s1_uo, r_s1_vo;
   logic [SW-1:0]   w_uo, w_vo;
   logic            w_en, w_acc;

   assign w_en     = !r_out_vld | out_ready;
   assign in_ready = w_en & ((r_state == ST_PRIME) | (r_state == ST_RUN));
   assign w_acc    = in_valid & in_ready;

   // framing FSM, chroma window, luma delay line and shift-time tap
   always_ff @(posedge CLOCK_50_I) begin
      if (Reset) begin
         r_state      <= ST_IDLE;
         r_beat       <= '0;
         r_line       <= '0;
         r_flush      <= '0;
         r_s0_y       <= '0;
         r_s0_vld     <= 1'b0;
         r_s0_last    <= 1'b0;
         r_frame_done <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            r_wu[i] <= '0;
            r_wv[i] <= '0;
         end
         for (int i = 0; i < 3; i++) r_dly[i] <= '0;
      end else begin
         r_frame_done <= 1'b0;
         // a stage slot with no shift carries a bubble
         if (w_en) begin
            r_s0_vld  <= 1'b0;
            r_s0_last <= 1'b0;
         end
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_PRIME;
                  r_line  <= '0;
                  r_beat  <= '0;
                  r_flush <= '0;
               end
            end
            ST_PRIME: begin
               if (w_acc) begin
                  // left edge: every tap starts as u0/v0
                  for (int i = 0; i < 6; i++) begin
                     r_wu[i] <= in_u;
                     r_wv[i] <= in_v;
                  end
                  r_dly[0] <= in_y;
                  r_dly[1] <= r_dly[0];
                  r_dly[2] <= r_dly[1];
                  r_s0_y   <= r_dly[2];
                  r_beat   <= PW'(1);
                  r_state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_acc) begin
                  for (int i = 0; i < 5; i++) begin
                     r_wu[i] <= r_wu[i+1];
                     r_wv[i] <= r_wv[i+1];
                  end
                  r_wu[5]  <= in_u;
                  r_wv[5]  <= in_v;
                  r_dly[0] <= in_y;
                  r_dly[1] <= r_dly[0];
                  r_dly[2] <= r_dly[1];
                  // the delay line's oldest entry is the luma of pair beat-3
                  r_s0_y   <= r_dly[2];
                  r_s0_vld <= (r_beat >= PW'(3));
                  r_beat   <= r_beat + PW'(1);
                  if (r_beat == PW'(P - 1)) begin
                     r_state <= ST_FLUSH;
                     r_flush <= '0;
                  end
               end
            end
            ST_FLUSH: begin
               if (w_en) begin
                  // right edge: keep re-inserting the last chroma sample
                  for (int i = 0; i < 5; i++) begin
                     r_wu[i] <= r_wu[i+1];
                     r_wv[i] <= r_wv[i+1];
                  end
                  r_dly[0]  <= '0;
                  r_dly[1]  <= r_dly[0];
                  r_dly[2]  <= r_dly[1];
                  r_s0_y    <= r_dly[2];
                  r_s0_vld  <= 1'b1;
                  r_s0_last <= (r_flush == 2'd2);
                  r_flush   <= r_flush + 2'd1;
                  if (r_flush == 2'd2) begin
                     r_line  <= r_line + LW'(1);
                     r_beat  <= '0;
                     r_state <= (r_line == LW'(NUM_LINES - 1)) ? ST_DONE : ST_PRIME;
                  end
               end
            end
            ST_DONE: begin
               // wait for the frame's final pair to leave before signalling
               if (r_out_vld & out_ready & r_out_last) begin
                  r_frame_done <= 1'b1;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef M1_FIR6_EN
   int w_fir_u, w_fir_v;
   // 6-tap symmetric FIR for the half-pel (odd pixel) chroma
   always_comb begin
      w_fir_u = FIR_C0 * (int'(r_wu[0]) + int'(r_wu[5]))
              - FIR_C1 * (int'(r_wu[1]) + int'(r_wu[4]))
              + FIR_C2 * (int'(r_wu[2]) + int'(r_wu[3])) + FIR_RND;
      w_fir_v = FIR_C0 * (int'(r_wv[0]) + int'(r_wv[5]))
              - FIR_C1 * (int'(r_wv[1]) + int'(r_wv[4]))
              + FIR_C2 * (int'(r_wv[2]) + int'(r_wv[3])) + FIR_RND;
      w_uo = SW'(clip_sw(w_fir_u >>> FIR_SHIFT, SW));
      w_vo = SW'(clip_sw(w_fir_v >>> FIR_SHIFT, SW));
   end
`else
   // rounded average of the two nearest chroma samples for the odd pixel
   always_comb begin
      w_uo = SW'((int'(r_wu[2]) + int'(r_wu[3]) + 1) >>> 1);
      w_vo = SW'((int'(r_wv[2]) + int'(r_wv[3]) + 1) >>> 1);
   end
`endif

   // stage 1 data plus valid/last tracking through stages 2 and 3
   always_ff @(posedge CLOCK_50_I) begin
      if (Reset) begin
         r_s1_y     <= '0;
         r_s1_ue    <= '0;
         r_s1_ve    <= '0;
         r_s1_uo    <= '0;
         r_s1_vo    <= '0;
         r_s1_vld   <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s2_vld   <= 1'b0;
         r_s2_last  <= 1'b0;
         r_out_vld  <= 1'b0;
         r_out_last <= 1'b0;
      end else if (w_en) begin
         r_s1_y     <= r_s0_y;
         r_s1_ue    <= r_wu[2];
         r_s1_ve    <= r_wv[2];
         r_s1_uo    <= w_uo;
         r_s1_vo    <= w_vo;
         r_s1_vld   <= r_s0_vld;
         r_s1_last  <= r_s0_last;
         r_s2_vld   <= r_s1_vld;
         r_s2_last  <= r_s1_last;
         r_out_vld  <= r_s2_vld;
         r_out_last <= r_s2_last;
      end
   end

   yuv2rgb_csc #(.SW(SW)) u_csc_even (
      .i_clk (CLOCK_50_I),
      .i_rst (Reset),
      .i_en  (w_en),
      .i_y   (r_s1_y[2*SW-1:SW]),
      .i_u   (r_s1_ue),
      .i_v   (r_s1_ve),
      .o_rgb (out_rgb0)
   );

   yuv2rgb_csc #(.SW(SW)) u_csc_odd (
      .i_clk (CLOCK_50_I),
      .i_rst (Reset),
      .i_en  (w_en),
      .i_y   (r_s1_y[SW-1:0]),
      .i_u   (r_s1_uo),
      .i_v   (r_s1_vo),
      .o_rgb (out_rgb1)
   );

   assign out_valid  = r_out_vld;
   assign out_last   = r_out_last;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_m1_upsample_csc.sv
// Directed-plus-random bench for m1_upsample_csc with a pixel-level reference model.
// Latency: checks every output pair in order against the model, plus frame_done timing.
// Backpressure: exercises held-off out_ready, random ready and input gaps.
module tb_m1_upsample_csc;

   localparam int LW = 8;
   localparam int NL = 2;
   localparam int P  = LW / 2;
   localparam int NB = NL * P;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, in_ready, out_valid, out_ready, out_last, frame_done;
   logic [15:0] in_y;
   logic [7:0]  in_u, in_v;
   logic [23:0] out_rgb0, out_rgb1;

   int total = 0;
   int bad   = 0;

   int ys [NL][LW];
   int us [NL][P];
   int vs [NL][P];
   logic [23:0] obs0 [NB];
   logic [23:0] obs1 [NB];

   always #5 clk = ~clk;

   m1_upsample_csc #(.LINE_WIDTH(LW), .NUM_LINES(NL), .SW(8)) dut (
      .CLOCK_50_I (clk),
      .Reset      (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_y       (in_y),
      .in_u       (in_u),
      .in_v       (in_v),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_rgb0   (out_rgb0),
      .out_rgb1   (out_rgb1),
      .out_last   (out_last),
      .frame_done (frame_done)
   );

   function automatic int clip8(input int x);
      return (x < 0) ? 0 : ((x > 255) ? 255 : x);
   endfunction

   // chroma sample of pair k with edges replicated
   function automatic int tap(input int l, input int k, input bit isv);
      int kk;
      kk = (k < 0) ? 0 : ((k > P - 1) ? P - 1 : k);
      return isv ? vs[l][kk] : us[l][kk];
   endfunction

   // interpolated chroma sitting between pairs k and k+1
   function automatic int odd_ch(input int l, input int k, input bit isv);
      int s;
`ifdef M1_FIR6_EN
      s = 21 * (tap(l, k-2, isv) + tap(l, k+3, isv)) - 52 * (tap(l, k-1, isv) + tap(l, k+2, isv))
        + 159 * (tap(l, k, isv) + tap(l, k+1, isv)) + 128;
      return clip8(s >>> 8);
`else
      s = tap(l, k, isv) + tap(l, k+1, isv) + 1;
      return s / 2;
`endif
   endfunction

   function automatic logic [23:0] rgb(input int yy, input int uu, input int vv);
      int y, u, v, r, g, b;
      y = yy - 16;
      u = uu - 128;
      v = vv - 128;
      r = clip8((76284 * y + 104595 * v) >>> 16);
      g = clip8((76284 * y - 25624 * u - 53281 * v) >>> 16);
      b = clip8((76284 * y + 132251 * u) >>> 16);
      return {8'(r), 8'(g), 8'(b)};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // 0 grey, 1 black, 2 saturating red, 3 U impulse at pair 2, 4 random
   task automatic fill(input int mode);
      for (int l = 0; l < NL; l++) begin
         for (int p = 0; p < LW; p++)
            ys[l][p] = (mode == 0) ? 128 : (mode == 2) ? 255 : (mode == 4) ? int'($urandom_range(0, 255)) : 16;
         for (int k = 0; k < P; k++) begin
            us[l][k] = (mode == 4) ? int'($urandom_range(0, 255)) : ((mode == 3 && k == 2) ? 228 : 128);
            vs[l][k] = (mode == 4) ? int'($urandom_range(0, 255)) : ((mode == 2) ? 255 : 128);
         end
      end
   endtask

   // bp: 0 none, 1 out_ready low for 5 cycles mid-line, 2 random ready and input gaps
   task automatic run_frame(input int bp, input bit mid_start);
      int nin, nout, fd_cnt, last_cyc, l, k, cyc;
      bit hold, done;
      logic [47:0] held;
      logic [23:0] e0, e1;
      nin = 0; nout = 0; fd_cnt = 0; last_cyc = -10; hold = 0; done = 0; held = '0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (cyc = 0; cyc < 600 && !done; cyc++) begin
         out_ready = 1'b1;
         if (bp == 1 && cyc >= 8 && cyc < 13) out_ready = 1'b0;
         if (bp == 2) out_ready = ($urandom_range(0, 2) != 0);
         in_valid = (nin < NB) && (bp != 2 || $urandom_range(0, 3) != 0);
         l = (nin < NB) ? nin / P : 0;
         k = nin % P;
         in_y  = {8'(ys[l][2*k]), 8'(ys[l][2*k+1])};
         in_u  = 8'(us[l][k]);
         in_v  = 8'(vs[l][k]);
         start = (mid_start && cyc == 6);
         #1;
         if (hold) check("hold_stable", {out_valid, out_rgb0, out_rgb1}, {1'b1, held});
         if (out_valid && !out_ready) begin
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            hold = 1;
            held = {out_rgb0, out_rgb1};
         end else begin
            hold = 0;
         end
         if (out_valid && out_ready) begin
            if (nout < NB) begin
               l  = nout / P;
               k  = nout % P;
               e0 = rgb(ys[l][2*k], us[l][k], vs[l][k]);
               e1 = rgb(ys[l][2*k+1], odd_ch(l, k, 1'b0), odd_ch(l, k, 1'b1));
               check("beat", {15'd0, out_rgb0, out_rgb1, out_last}, {15'd0, e0, e1, (k == P - 1)});
               obs0[nout] = out_rgb0;
               obs1[nout] = out_rgb1;
               if (nout == NB - 1) last_cyc = cyc;
            end else begin
               check("extra_beat", 64'(nout), 64'(NB - 1));
            end
            nout++;
         end
         if (frame_done) begin
            fd_cnt++;
            check("frame_done_time", 64'(cyc), 64'(last_cyc + 1));
         end
         if (in_valid && in_ready) nin++;
         if (nout >= NB && fd_cnt > 0 && cyc > last_cyc + 4) done = 1;
         @(negedge clk);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      start     = 1'b0;
      check("beat_count", 64'(nout), 64'(NB));
      check("frame_done_count", 64'(fd_cnt), 64'd1);
      #1;
      check("idle_in_ready", {63'd0, in_ready}, 64'd0);
   endtask

   initial begin
      int acc;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_y = '0; in_u = '0; in_v = '0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs", {14'd0, in_ready, out_valid, out_last, frame_done, out_rgb0, out_rgb1}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // flat grey: every channel 130
      fill(0);
      run_frame(0, 1'b0);
      check("grey_even", {40'd0, obs0[0]}, {40'd0, 24'h828282});
      check("grey_odd_last", {40'd0, obs1[NB-1]}, {40'd0, 24'h828282});

      // black, then saturating red
      fill(1);
      run_frame(0, 1'b0);
      check("black", {16'd0, obs0[1], obs1[2]}, 64'd0);
      fill(2);
      run_frame(0, 1'b0);
      check("sat_red", {56'd0, obs0[0][23:16]}, 64'd255);

      // chroma impulse at u2 with a start pulse issued mid-frame
      fill(3);
      run_frame(0, 1'b1);
`ifdef M1_FIR6_EN
      check("impulse_odd_b", {56'd0, obs1[1][7:0]}, 64'd125);
`else
      check("impulse_odd_b", {56'd0, obs1[1][7:0]}, 64'd100);
`endif
      check("impulse_even_b", {56'd0, obs0[2][7:0]}, 64'd201);

      // random content under held and random backpressure
      fill(4);
      run_frame(1, 1'b0);
      fill(4);
      run_frame(2, 1'b0);

      // reset after two accepted beats, then a clean frame
      fill(4);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      acc = 0;
      for (int c = 0; c < 20 && acc < 2; c++) begin
         in_valid = 1'b1;
         in_y = {8'(ys[0][2*acc]), 8'(ys[0][2*acc+1])};
         in_u = 8'(us[0][acc]);
         in_v = 8'(vs[0][acc]);
         #1;
         if (in_ready) acc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("partial_accepted", 64'(acc), 64'd2);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("midline_reset", {14'd0, in_ready, out_valid, out_last, frame_done, out_rgb0, out_rgb1}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      fill(4);
      run_frame(0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
